l2_cache_nway: RTL and testbench
================================

Name: l2_cache_nway

Overview:
- Parametrised N-way set-associative, write-back, write-allocate L2 cache; successor to the direct-mapped-style L2.
- Sits between the L1 arbiter (256-bit line requests) and physical memory (256-bit bursts).
- Adds configurable associativity and tree pseudo-LRU replacement, with an invalid-way-first victim policy.
- Adds a write-back counter, and saturating performance counters under a build macro.

Parameters:
- s_offset, 5, byte-offset bits; line = 2**s_offset bytes (fixed 32 for the 256-bit bus).
- s_index, 3, set-index bits; num_sets = 2**s_index.
- num_ways, 4, associativity; power of two, 2..16.
- s_tag, 32 - s_offset - s_index, tag bits.
- s_line, 8*2**s_offset, line width in bits (256).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset (one clock; reset is synchronous and active-low).
- mem_address  in  32  line request address; offset bits ignored.
- mem_read  in  1  read request; held until mem_resp.
- mem_write  in  1  write request; held until mem_resp.
- mem_wdata  in  s_line  full-line write data.
- mem_rdata  out  s_line  read data; valid only while mem_resp=1.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_address  out  32  line-aligned memory address.
- pmem_rdata  in  s_line  fill data.
- pmem_wdata  out  s_line  write-back data.
- pmem_read  out  1  fill request; held until pmem_resp.
- pmem_write  out  1  write-back request; held until pmem_resp.
- pmem_resp  in  1  memory completion pulse.
- hit_counter  out  32  hits since reset.
- miss_counter  out  32  misses since reset.
- wb_counter  out  32  dirty write-backs since reset.

Behaviour:
- Storage per set and way: valid, dirty, tag, line. Per set: (num_ways-1)-bit PLRU tree. All flops.
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - All valid, dirty and PLRU bits cleared; data/tag contents don't-care.
  - All outputs 0; counters 0.
  - Reset mid-WRITEBACK or mid-FILL abandons the transaction; pmem_read/pmem_write are low the next cycle. A late pmem_resp is ignored.
- State IDLE: if mem_read|mem_write, latch address, wdata and op (mem_write wins if both are asserted), then go to CHECK. No output is asserted in IDLE.
- State CHECK: compare the latched tag against all valid ways of the indexed set.
  - Hit, same cycle: mem_resp=1 and mem_rdata = line of the hit way. A write replaces the whole line and sets dirty. PLRU is updated to point away from the hit way. Next state IDLE.
  - Hit latency: 2 cycles from the request edge (request seen at edge 0, mem_resp high during cycle 1).
  - Miss: choose the victim as the lowest-index invalid way, otherwise the PLRU victim. If victim valid and dirty, go to WRITEBACK; else go to FILL.
- State WRITEBACK:
  - Outputs: pmem_write=1, pmem_address={victim tag, index, 0s}, pmem_wdata=victim line.
  - On pmem_resp: clear victim dirty, increment wb_counter, go to FILL.
- State FILL:
  - Outputs: pmem_read=1, pmem_address={req tag, index, 0s}.
  - On pmem_resp: write victim line and tag, set valid=1, dirty=0, go to CHECK (the re-check hits).
- The re-check hit after a fill does not increment hit_counter. Each request counts exactly once, as hit or miss, on its first CHECK.
- mem_resp is never asserted two consecutive cycles. A new request is accepted no earlier than the IDLE cycle after mem_resp.
- pmem_read and pmem_write are never high simultaneously.
- Address offset bits are zero in every pmem_address.
- Requests dropped before mem_resp: undefined (protocol violation); an assertion flags it in simulation.

Optional Feature:
- Macro L2_PERF_CTR_EN.
- Defined: hit_counter, miss_counter and wb_counter increment as above and saturate at 32'hFFFF_FFFF.
- Undefined: all three counters are tied to 0 and no counter flops are built. Cache behaviour is otherwise identical.

Test Plan:
- Reset, then read 0x0000_0100 with pmem_rdata=line A → one FILL at pmem_address 0x0000_0100; mem_resp with A; miss_counter=1, hit_counter=0.
- Reread 0x0000_0100 → mem_resp 2 cycles after request, no pmem activity; hit_counter=1.
- Defaults, set 0: read 0x000, 0x100, 0x200 and 0x300 (4 fills), reread 0x000, then read 0x400 → victim is the 0x100 way (PLRU); a later read of 0x000 hits with no fill.
- Write line B to 0x000 (hit), then force its eviction → WRITEBACK at pmem_address 0x000 with pmem_wdata=B before the FILL; wb_counter=1.
- Assert rst=0 during a FILL (pmem_read=1) → pmem_read=0 next cycle; all lines invalid; the next read of the same address misses.
- Macro undefined: repeat the first two scenarios → all counters read 0, data responses unchanged.

Source files
------------

// File: rtl/l2_cache_nway.sv
// N-way set-associative write-back/write-allocate L2 with tree pseudo-LRU; hits respond 2 cycles after request, requests held until mem_resp.
// Build macro L2_PERF_CTR_EN enables saturating hit/miss/write-back counters; otherwise all three read 0.
module l2_cache_nway #(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int num_ways = 4,
    parameter int s_tag    = 32 - s_offset - s_index,
    parameter int s_line   = 8 * 2**s_offset
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_address,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [s_line-1:0] mem_wdata,
    output logic [s_line-1:0] mem_rdata,
    output logic              mem_resp,
    output logic [31:0]       pmem_address,
    input  logic [s_line-1:0] pmem_rdata,
    output logic [s_line-1:0] pmem_wdata,
    output logic              pmem_read,
    output logic              pmem_write,
    input  logic              pmem_resp,
    output logic [31:0]       hit_counter,
    output logic [31:0]       miss_counter,
    output logic [31:0]       wb_counter
);
    localparam int num_sets = 2**s_index;
    localparam int s_way    = $clog2(num_ways);

    typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_t;
    state_t r_state, w_state_nxt;

    logic [31-s_offset:0] r_line;
    logic [s_line-1:0]    r_wdata;
    logic                 r_is_write;
    logic [s_way-1:0]     r_victim;

    logic [num_ways-1:0] r_valid [num_sets];
    logic [num_ways-1:0] r_dirty [num_sets];
    logic [num_ways-2:0] r_plru  [num_sets];
    logic [s_tag-1:0]    r_tag   [num_sets][num_ways];
    logic [s_line-1:0]   r_data  [num_sets][num_ways];

    logic [s_tag-1:0]    w_tag;
    logic [s_index-1:0]  w_idx;
    logic                w_hit, w_inv_found;
    logic [s_way-1:0]    w_hit_way, w_inv_way, w_plru_way, w_victim;
    logic [num_ways-2:0] w_plru_upd;
    logic                w_unused;

    assign w_tag    = r_line[s_tag+s_index-1:s_index];
    assign w_idx    = r_line[s_index-1:0];
    assign w_unused = ^mem_address[s_offset-1:0];

    // Tree nodes are ordered so that level l decides bit l of the way number, LSB first.
    function automatic logic [s_way-1:0] node_of(input int l, input logic [s_way-1:0] way);
        return s_way'((1 << l) - 1 + (int'(way) % (1 << l)));
    endfunction

    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = s_way'(w);
            end
            if (!r_valid[w_idx][w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = s_way'(w);
            end
        end
    end

    always_comb begin
        w_plru_way = '0;
        w_plru_upd = r_plru[w_idx];
        for (int l = 0; l < s_way; l++) begin
            if (r_plru[w_idx][node_of(l, w_plru_way)])
                w_plru_way = w_plru_way | s_way'(1 << l);
            w_plru_upd[node_of(l, w_hit_way)] = ~1'(w_hit_way >> l);
        end
        w_victim = w_inv_found ? w_inv_way : w_plru_way;
    end

    always_comb begin
        w_state_nxt  = r_state;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (r_state)
            IDLE: begin
                if (mem_read || mem_write)
                    w_state_nxt = CHECK;
            end
            CHECK: begin
                if (w_hit) begin
                    mem_resp    = 1'b1;
                    mem_rdata   = r_data[w_idx][w_hit_way];
                    w_state_nxt = IDLE;
                end else if (!w_inv_found && r_dirty[w_idx][w_plru_way]) begin
                    w_state_nxt = WRITEBACK;
                end else begin
                    w_state_nxt = FILL;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {r_tag[w_idx][r_victim], w_idx, {s_offset{1'b0}}};
                pmem_wdata   = r_data[w_idx][r_victim];
                if (pmem_resp)
                    w_state_nxt = FILL;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {w_tag, w_idx, {s_offset{1'b0}}};
                if (pmem_resp)
                    w_state_nxt = CHECK;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_line     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_victim   <= '0;
            for (int s = 0; s < num_sets; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        r_line     <= mem_address[31:s_offset];
                        r_wdata    <= mem_wdata;
                        r_is_write <= mem_write;
                    end
                end
                CHECK: begin
                    if (w_hit) begin
                        r_plru[w_idx] <= w_plru_upd;
                        if (r_is_write)
                            r_dirty[w_idx][w_hit_way] <= 1'b1;
                    end else begin
                        r_victim <= w_victim;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp)
                        r_dirty[w_idx][r_victim] <= 1'b0;
                end
                FILL: begin
                    if (pmem_resp) begin
                        r_valid[w_idx][r_victim] <= 1'b1;
                        r_dirty[w_idx][r_victim] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line and tag storage carries no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (r_state == CHECK && w_hit && r_is_write)
            r_data[w_idx][w_hit_way] <= r_wdata;
        if (r_state == FILL && pmem_resp) begin
            r_data[w_idx][r_victim] <= pmem_rdata;
            r_tag[w_idx][r_victim]  <= w_tag;
        end
    end

`ifdef L2_PERF_CTR_EN
    logic [31:0] r_hit_cnt, r_miss_cnt, r_wb_cnt;
    logic        r_recheck;

    // The CHECK that follows a fill is a re-check and does not count again.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_wb_cnt   <= '0;
            r_recheck  <= 1'b0;
        end else begin
            if (r_state == FILL && pmem_resp)
                r_recheck <= 1'b1;
            else if (r_state == IDLE)
                r_recheck <= 1'b0;
            if (r_state == CHECK && !r_recheck) begin
                if (w_hit) begin
                    if (r_hit_cnt != '1)
                        r_hit_cnt <= r_hit_cnt + 32'd1;
                end else if (r_miss_cnt != '1) begin
                    r_miss_cnt <= r_miss_cnt + 32'd1;
                end
            end
            if (r_state == WRITEBACK && pmem_resp && r_wb_cnt != '1)
                r_wb_cnt <= r_wb_cnt + 32'd1;
        end
    end

    assign hit_counter  = r_hit_cnt;
    assign miss_counter = r_miss_cnt;
    assign wb_counter   = r_wb_cnt;
`else
    assign hit_counter  = '0;
    assign miss_counter = '0;
    assign wb_counter   = '0;
`endif

    a_req_held: assert property (@(posedge clk) disable iff (!rst)
        (r_state != IDLE && !mem_resp) |-> (mem_read || mem_write));

endmodule

// File: tb/tb_l2_cache_nway.sv
// Randomized bench for l2_cache_nway against a line-level cache/memory reference model.
module tb_l2_cache_nway;
    localparam int NW = 4;
    localparam int NS = 8;
    localparam int LV = 2;

    logic         clk, rst;
    logic [31:0]  mem_address;
    logic         mem_read, mem_write;
    logic [255:0] mem_wdata, mem_rdata;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_rdata, pmem_wdata;
    logic         pmem_read, pmem_write, pmem_resp;
    logic [31:0]  hit_counter, miss_counter, wb_counter;

    l2_cache_nway dut (
        .clk(clk), .rst(rst),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_address(pmem_address), .pmem_rdata(pmem_rdata), .pmem_wdata(pmem_wdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .hit_counter(hit_counter), .miss_counter(miss_counter), .wb_counter(wb_counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: what the program should read (golden), what physical memory holds (pmem),
    // and a tag directory with a per-set binary decision tree for replacement.
    logic [255:0] golden [int unsigned];
    logic [255:0] pmem   [int unsigned];
    bit           m_valid [NS][NW];
    bit           m_dirty [NS][NW];
    int unsigned  m_tag   [NS][NW];
    bit           m_tree  [NS][NW];
    int           m_hits, m_misses, m_wbs;

    bit           g_fill_seen, g_wb_seen;
    logic [31:0]  g_wb_a;
    logic [255:0] g_wb_d;

    function automatic logic [255:0] pat(input int unsigned la);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = la * 32'h9E37_79B1 + k;
        return r;
    endfunction

    function automatic logic [255:0] get_g(input int unsigned la);
        if (golden.exists(la)) return golden[la];
        return pat(la);
    endfunction

    function automatic logic [255:0] get_p(input int unsigned la);
        if (pmem.exists(la)) return pmem[la];
        return pat(la);
    endfunction

    // Heap-numbered tree (root 1); level l chooses bit l of the way, LSB first.
    function automatic int tree_victim(input int s);
        int v = 0;
        for (int l = 0; l < LV; l++)
            if (m_tree[s][(1 << l) + v]) v += (1 << l);
        return v;
    endfunction

    function automatic void tree_touch(input int s, input int w);
        for (int l = 0; l < LV; l++)
            m_tree[s][(1 << l) + (w % (1 << l))] = (((w >> l) & 1) == 0);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tree[s][w] = 0;
            end
        m_hits = 0; m_misses = 0; m_wbs = 0;
        golden.delete();
        foreach (pmem[k]) golden[k] = pmem[k];
    endfunction

    task automatic check_counters();
        int e_hit, e_miss, e_wb;
`ifdef L2_PERF_CTR_EN
        e_hit = m_hits; e_miss = m_misses; e_wb = m_wbs;
`else
        e_hit = 0; e_miss = 0; e_wb = 0;
`endif
        check_eq("hit_counter", hit_counter, e_hit);
        check_eq("miss_counter", miss_counter, e_miss);
        check_eq("wb_counter", wb_counter, e_wb);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        @(negedge clk);
        model_reset();
        check_eq("rst_mem_resp", mem_resp, 0);
        check_eq("rst_pmem_rw", {pmem_read, pmem_write}, 0);
        check_eq("rst_pmem_addr", pmem_address, 0);
        check_counters();
        rst = 1'b1;
    endtask

    task automatic do_req(input logic [31:0] addr, input bit wr, input bit rd_too, input logic [255:0] wd);
        int unsigned la, wb_la, tg;
        int idx, way, vic, cyc, dly;
        bit hit, exp_wb, got, s_wb, s_fill, both, order_bad;
        logic [255:0] exp_rd, exp_wbd, rd, wb_d;
        logic [31:0] wb_a, fill_a;

        la = addr >> 5; idx = int'(la % NS); tg = la / NS;
        hit = 0; way = 0; exp_wb = 0; wb_la = 0; exp_wbd = '0;
        for (int w = 0; w < NW; w++)
            if (m_valid[idx][w] && m_tag[idx][w] == tg) begin hit = 1; way = w; end
        if (hit) begin
            m_hits++;
        end else begin
            m_misses++;
            vic = -1;
            for (int w = NW - 1; w >= 0; w--) if (!m_valid[idx][w]) vic = w;
            if (vic < 0) vic = tree_victim(idx);
            if (m_valid[idx][vic] && m_dirty[idx][vic]) begin
                exp_wb = 1; m_wbs++;
                wb_la = m_tag[idx][vic] * NS + idx;
                exp_wbd = get_g(wb_la);
            end
            m_valid[idx][vic] = 1; m_tag[idx][vic] = tg; m_dirty[idx][vic] = 0; way = vic;
        end
        tree_touch(idx, way);
        exp_rd = get_g(la);
        if (wr) begin m_dirty[idx][way] = 1; golden[la] = wd; end

        @(negedge clk);
        mem_address = addr; mem_write = wr; mem_read = !wr || rd_too; mem_wdata = wd;
        got = 0; s_wb = 0; s_fill = 0; both = 0; order_bad = 0; cyc = 0; dly = -1;
        rd = '0; wb_a = '0; wb_d = '0; fill_a = '0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            pmem_resp = 1'b0;
            if (pmem_read && pmem_write) both = 1;
            if (pmem_write && !s_wb) begin s_wb = 1; wb_a = pmem_address; wb_d = pmem_wdata; end
            if (pmem_read && !s_fill) begin
                s_fill = 1; fill_a = pmem_address;
                if (exp_wb && !s_wb) order_bad = 1;
            end
            if (pmem_read || pmem_write) begin
                if (dly < 0) dly = $urandom_range(0, 3);
                if (dly == 0) begin
                    if (pmem_write) pmem[pmem_address >> 5] = pmem_wdata;
                    else pmem_rdata = get_p(pmem_address >> 5);
                    pmem_resp = 1'b1; dly = -1;
                end else begin
                    dly--;
                end
            end
            if (mem_resp) begin got = 1; rd = mem_rdata; mem_read = 1'b0; mem_write = 1'b0; end
        end
        mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;

        check_eq("resp_seen", got, 1);
        if (!wr) check_eq("rdata", rd, exp_rd);
        check_eq("fill_seen", s_fill, !hit);
        check_eq("wb_seen", s_wb, exp_wb);
        check_eq("pmem_excl_order", {both, order_bad}, 0);
        if (hit) check_eq("hit_latency", cyc, 1);
        if (s_fill && !hit) check_eq("fill_addr", fill_a, la << 5);
        if (s_wb && exp_wb) begin
            check_eq("wb_addr", wb_a, wb_la << 5);
            check_eq("wb_data", wb_d, exp_wbd);
        end
        g_fill_seen = s_fill; g_wb_seen = s_wb; g_wb_a = wb_a; g_wb_d = wb_d;

        @(negedge clk);
        check_eq("resp_one_cycle", mem_resp, 0);
        check_counters();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] line_b, wd;
        bit wb_b_seen;
        int cyc;
        logic [31:0] addr;

        rst = 1'b0; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0; mem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        for (int k = 0; k < 8; k++) line_b[k*32 +: 32] = 32'hB0B0_0000 + k;

        // Cold miss then hit on the same line.
        do_reset();
        do_req(32'h0000_0100, 0, 0, '0);
        do_req(32'h0000_0100, 0, 0, '0);

        // Fill set 0, make 0x000 most recent, then 0x400 must evict the 0x100 line.
        do_reset();
        do_req(32'h0000_0000, 0, 0, '0);
        do_req(32'h0000_0100, 0, 0, '0);
        do_req(32'h0000_0200, 0, 0, '0);
        do_req(32'h0000_0300, 0, 0, '0);
        do_req(32'h0000_0000, 0, 0, '0);
        do_req(32'h0000_0400, 0, 0, '0);
        do_req(32'h0000_0000, 0, 0, '0);
        check_eq("a000_kept", g_fill_seen, 0);

        // Dirty line B at 0x000 must be written back when it is evicted.
        do_req(32'h0000_0000, 1, 0, line_b);
        wb_b_seen = 0;
        for (int k = 5; k <= 9; k++) begin
            do_req(32'(k) << 8, 0, 0, '0);
            if (g_wb_seen && g_wb_a == 32'h0 && g_wb_d == line_b) wb_b_seen = 1;
        end
        check_eq("wb_of_line_b", wb_b_seen, 1);

        // Reset in the middle of a fill, with a late memory response afterwards.
        do_req(32'h0000_0600, 1, 0, ~line_b);
        @(negedge clk);
        mem_address = 32'h0000_0A40; mem_read = 1'b1;
        cyc = 0;
        while (!pmem_read && cyc < 20) begin @(negedge clk); cyc++; end
        check_eq("rst_fill_reached", pmem_read, 1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_abort_pread", {pmem_read, pmem_write}, 0);
        mem_read = 1'b0; rst = 1'b1; pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        model_reset();
        check_eq("late_resp_ignored", {mem_resp, pmem_read, pmem_write}, 0);
        check_counters();
        do_req(32'h0000_0A40, 0, 0, '0);
        check_eq("post_rst_miss", g_fill_seen, 1);
        do_req(32'h0000_0000, 0, 0, '0);

        // Random traffic over 8 tags x 4 sets so that evictions are frequent.
        for (int n = 0; n < 300; n++) begin
            addr = ($urandom_range(0, 7) << 8) | ($urandom_range(0, 3) << 5) | $urandom_range(0, 31);
            for (int k = 0; k < 8; k++) wd[k*32 +: 32] = $urandom();
            do_req(addr, $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1, wd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
